// File: rtl/sequence_generator_if.sv
// Control/data link between a job controller and the serial pattern generator.
// The controller owns the job request; the generator owns the serial stream.
interface sequence_generator_if #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5,
  parameter int REP_W   = 8,
  parameter int GAP_W   = 4
);
  logic               start;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic [REP_W-1:0]   reps;
  logic [GAP_W-1:0]   gap;
  logic               o;
  logic               o_valid;
  logic               busy;
  logic               done;

  modport master (
    output start, pattern, len, reps, gap,
    input  o, o_valid, busy, done
  );

  modport slave (
    input  start, pattern, len, reps, gap,
    output o, o_valid, busy, done
  );
endinterface

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first,
// repeated reps times with gap idle cycles between repetitions.
module sequence_generator #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5,
  parameter int REP_W   = 8,
  parameter int GAP_W   = 4
) (
  input logic                 clk,
  input logic                 rst,
  sequence_generator_if.slave link
);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t             state;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   last_q;
  logic [LEN_W-1:0]   idx;
  logic [REP_W-1:0]   rem;
  logic [GAP_W-1:0]   gap_q;
  logic [GAP_W-1:0]   gcnt;
  logic               o_q;
  logic               valid_q;
  logic               busy_q;
  logic               done_q;
  logic [LEN_W-1:0]   eff_last;

  function automatic logic bit_at(
    input logic [MAX_LEN-1:0] p,
    input logic [LEN_W-1:0]   i
  );
    logic [MAX_LEN-1:0] s;
    s = p >> i;
    return s[0];
  endfunction

  // Index of the first bit sent; out-of-range lengths mean a full pattern.
  always_comb begin
    if (link.len == '0 || link.len > LEN_W'(MAX_LEN))
      eff_last = LEN_W'(MAX_LEN - 1);
    else
      eff_last = link.len - LEN_W'(1);
  end

  // Job FSM with all outputs registered alongside the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pat_q   <= '0;
      last_q  <= '0;
      idx     <= '0;
      rem     <= '0;
      gap_q   <= '0;
      gcnt    <= '0;
      o_q     <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          o_q     <= 1'b0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          if (link.start) begin
            pat_q  <= link.pattern;
            last_q <= eff_last;
            gap_q  <= link.gap;
            rem    <= link.reps;
            if (link.reps == '0) begin
              done_q <= 1'b1;
            end else begin
              state   <= SHIFT;
              idx     <= eff_last;
              o_q     <= bit_at(link.pattern, eff_last);
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (idx != '0) begin
            idx <= idx - LEN_W'(1);
            o_q <= bit_at(pat_q, idx - LEN_W'(1));
          end else begin
            rem <= rem - REP_W'(1);
            if (rem == REP_W'(1)) begin
              state   <= IDLE;
              done_q  <= 1'b1;
              o_q     <= 1'b0;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
            end else if (gap_q == '0) begin
              idx <= last_q;
              o_q <= bit_at(pat_q, last_q);
            end else begin
              state   <= GAP;
              gcnt    <= gap_q;
              o_q     <= 1'b0;
              valid_q <= 1'b0;
            end
          end
        end
        GAP: begin
          if (gcnt == GAP_W'(1)) begin
            state   <= SHIFT;
            idx     <= last_q;
            o_q     <= bit_at(pat_q, last_q);
            valid_q <= 1'b1;
          end else begin
            gcnt <= gcnt - GAP_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign link.o       = o_q;
  assign link.o_valid = valid_q;
  assign link.busy    = busy_q;
  assign link.done    = done_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Bench for sequence_generator: queue-based job model checked every cycle,
// directed literal cases, then randomized jobs with resets.
module tb_sequence_generator;

  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;
  localparam int REP_W   = 8;
  localparam int GAP_W   = 4;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  bit   armed = 1'b0;

  sequence_generator_if #(
    .MAX_LEN(MAX_LEN), .LEN_W(LEN_W),
    .REP_W(REP_W), .GAP_W(GAP_W)
  ) link ();

  sequence_generator #(
    .MAX_LEN(MAX_LEN), .LEN_W(LEN_W),
    .REP_W(REP_W), .GAP_W(GAP_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .link(link)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Each entry is one future cycle: {o, o_valid, busy, done}.
  logic [3:0] q[$];
  logic [3:0] cur = 4'b0;

  task automatic build(input logic [15:0] pat, input int len,
                       input int reps, input int gap);
    int l;
    l = (len == 0 || len > MAX_LEN) ? MAX_LEN : len;
    for (int r = 0; r < reps; r++) begin
      for (int k = l - 1; k >= 0; k--)
        q.push_back({pat[k], 1'b1, 1'b1, 1'b0});
      if (r < reps - 1)
        for (int g = 0; g < gap; g++)
          q.push_back(4'b0010);
    end
    q.push_back(4'b0001);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      cur = 4'b0;
      armed = 1'b1;
    end else begin
      if (!cur[1] && link.start === 1'b1)
        build(link.pattern, int'(link.len),
              int'(link.reps), int'(link.gap));
      cur = (q.size() > 0) ? q.pop_front() : 4'b0;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      logic [3:0] act;
      act = {link.o, link.o_valid, link.busy, link.done};
      tests++;
      if (act !== cur) begin
        fails++;
        $display("FAIL model t=%0t {o,v,busy,done} got %b want %b",
                 $time, act, cur);
      end
    end
  end

  // ---------------- directed helpers ----------------
  logic co[0:63];
  logic cv[0:63];
  logic cb[0:63];
  logic cd[0:63];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_job(input logic [15:0] pat, input int len,
                         input int reps, input int gap);
    link.pattern = pat;
    link.len     = LEN_W'(len);
    link.reps    = REP_W'(reps);
    link.gap     = GAP_W'(gap);
  endtask

  task automatic do_start(input logic [15:0] pat, input int len,
                          input int reps, input int gap);
    @(negedge clk);
    set_job(pat, len, reps, gap);
    link.start = 1'b1;
    @(negedge clk);
    link.start = 1'b0;
  endtask

  // Sample cycles 1..n; optionally raise start at cycle `at` with a new job.
  task automatic observe(input int n, input int at,
                         input logic [15:0] pat, input int len,
                         input int reps, input int gap);
    for (int c = 1; c <= n; c++) begin
      if (c > 1) @(negedge clk);
      co[c] = link.o;
      cv[c] = link.o_valid;
      cb[c] = link.busy;
      cd[c] = link.done;
      if (at != 0 && c == at) begin
        set_job(pat, len, reps, gap);
        link.start = 1'b1;
      end
      if (at != 0 && c == at + 1) link.start = 1'b0;
    end
  endtask

  function automatic int pk(input int sel, input int a, input int b);
    int r;
    r = 0;
    for (int c = a; c <= b; c++) begin
      case (sel)
        0: r = (r << 1) | int'(co[c]);
        1: r = (r << 1) | int'(cv[c]);
        2: r = (r << 1) | int'(cb[c]);
        default: r = (r << 1) | int'(cd[c]);
      endcase
    end
    return r;
  endfunction

  function automatic int cnt_busy(input int a, input int b);
    int r;
    r = 0;
    for (int c = a; c <= b; c++) r += int'(cb[c]);
    return r;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int s;
    int hits;
    int nv;
    bit got;
    link.start = 1'b0;
    set_job(16'h0, 0, 0, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_outputs",
        int'({link.o, link.o_valid, link.busy, link.done}), 0);

    // single pattern 1011
    do_start(16'h000B, 4, 1, 0);
    observe(6, 0, 16'h0, 0, 0, 0);
    chk("single_bits", pk(0, 1, 4), 'b1011);
    chk("single_valid", pk(1, 1, 6), 'b111100);
    chk("single_done", pk(3, 1, 6), 'b000010);
    chk("single_busy", cnt_busy(1, 6), 4);

    // two reps with gap 2
    do_start(16'h000B, 4, 2, 2);
    observe(12, 0, 16'h0, 0, 0, 0);
    chk("gap_bits", pk(0, 1, 10), 'b1011001011);
    chk("gap_valid", pk(1, 1, 12), 'b111100111100);
    chk("gap_done", pk(3, 1, 12), 'b000000000010);
    chk("gap_busy", cnt_busy(1, 12), 10);

    // empty job
    do_start(16'h000B, 4, 0, 0);
    observe(3, 0, 16'h0, 0, 0, 0);
    chk("reps0_done", pk(3, 1, 3), 'b100);
    chk("reps0_valid", pk(1, 1, 3), 0);
    chk("reps0_busy", cnt_busy(1, 3), 0);

    // len 0 means full width
    do_start(16'hA5A5, 0, 1, 0);
    observe(18, 0, 16'h0, 0, 0, 0);
    chk("len0_bits", pk(0, 1, 16), 'hA5A5);
    chk("len0_valid", pk(1, 1, 16), 'hFFFF);
    chk("len0_done", pk(3, 17, 18), 'b10);

    // reset during third shift cycle
    do_start(16'h000B, 4, 1, 0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_bit3", int'(link.o), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_out",
        int'({link.o, link.o_valid, link.busy, link.done}), 0);
    observe(4, 0, 16'h0, 0, 0, 0);
    chk("rst_mid_nodone", pk(3, 1, 4), 0);
    do_start(16'h000B, 4, 1, 0);
    observe(5, 0, 16'h0, 0, 0, 0);
    chk("rst_fresh_bits", pk(0, 1, 4), 'b1011);
    chk("rst_fresh_done", pk(3, 1, 5), 'b00001);

    // start while busy is ignored
    do_start(16'h000B, 4, 1, 0);
    observe(6, 2, 16'h0004, 3, 2, 0);
    chk("ignored_bits", pk(0, 1, 4), 'b1011);
    chk("ignored_valid", pk(1, 1, 6), 'b111100);

    // start on the done cycle
    do_start(16'h000B, 4, 1, 0);
    observe(10, 5, 16'h0006, 3, 1, 0);
    chk("b2b_valid", pk(1, 1, 9), 'b111101110);
    chk("b2b_done", pk(3, 1, 9), 'b000010001);
    chk("b2b_bits", pk(0, 6, 8), 'b110);

    // stream for a 1011 detector: three back-to-back reps
    do_start(16'h000B, 4, 3, 0);
    observe(13, 0, 16'h0, 0, 0, 0);
    s = pk(0, 1, 12);
    hits = 0;
    for (int k = 0; k <= 8; k++)
      if (((s >> (8 - k)) & 'hF) == 'hB) hits++;
    chk("loop_stream", s, 'hBBB);
    chk("loop_hits", hits, 3);
    chk("loop_done", int'(cd[13]), 1);

    // max reps, single-bit pattern
    do_start(16'h0001, 1, 255, 0);
    nv = 0;
    got = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      if (c > 0) @(negedge clk);
      if (link.o_valid === 1'b1) nv++;
      if (link.done === 1'b1) got = 1'b1;
    end
    chk("maxreps_done", int'(got), 1);
    chk("maxreps_count", nv, 255);

    // randomized jobs, mid-job input churn and occasional reset
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 199) == 0);
      link.start   = ($urandom_range(0, 3) == 0);
      link.pattern = 16'($urandom);
      link.len     = LEN_W'($urandom_range(0, 20));
      link.reps    = REP_W'($urandom_range(0, 4));
      link.gap     = GAP_W'($urandom_range(0, 3));
    end
    @(negedge clk);
    rst = 1'b0;
    link.start = 1'b0;
    repeat (400) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
